// File: rtl/digseg_scanner_pkg.sv
// digseg_scanner_pkg
//   Shared definitions for the multiplexed 7-segment scanner:
//   bus data width, control register address, reset patterns and the
//   scan FSM state type.
//   Optional feature macro used by importers: DIGSEG_SCAN_DIM_EN.

package digseg_scanner_pkg;

    localparam int DATA_W = 8;
    localparam int SEG_W  = 7;

    // Control register lives at the top of the 4-bit address space.
    localparam logic [3:0] CTRL_ADDR = 4'hF;

    // Segment pattern {a,b,c,d,e,f,g} for the character "0".
    localparam logic [SEG_W-1:0]  SEG_RESET   = 7'b1111110;
    // Digit register reset value: {dp, a..g} with dp off.
    localparam logic [DATA_W-1:0] DIGIT_RESET = {1'b0, SEG_RESET};

    localparam logic       CTRL_ENABLE_RESET = 1'b1;
    localparam logic [3:0] CTRL_BRIGHT_RESET = 4'hF;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/digseg_scan_timer.sv
// digseg_scan_timer
//   Slot timer for the digit scanner. Each slot is SCAN_DIV cycles: the
//   first BLANK_CYCLES are dead time, the rest light the current digit.
//   The digit index advances and wraps at the end of every slot.
//   While enable is low the timer sits in BLANK with the counter cleared
//   and the index held, so re-enabling replays a full blank phase.
//
//   The index/phase_on outputs are the state the timer will hold on the
//   next cycle. The caller registers them, so its registered outputs line
//   up cycle-for-cycle with the timer's own state.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   enable    in   scan enable
//   index     out  digit index for the next cycle
//   phase_on  out  next cycle is in the ON part of a slot
//   slot_end  out  current cycle is the last one of the slot

module digseg_scan_timer
    import digseg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [IDX_W-1:0] index,
    output logic             phase_on,
    output logic             slot_end
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0] index_q, index_nxt;

    assign slot_end = enable && (cnt_q == CNT_LAST);

    // NOTE: every variable gets a default before the branches so no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + 1'b1;
        index_nxt = index_q;
        if (!enable) begin
            state_nxt = SCAN_BLANK;
            cnt_nxt   = '0;
        end else if (slot_end) begin
            state_nxt = SCAN_BLANK;
            cnt_nxt   = '0;
            index_nxt = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end else if (state_q == SCAN_BLANK && cnt_q == BLANK_LAST) begin
            state_nxt = SCAN_ON;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN_BLANK;
            cnt_q   <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            index_q <= index_nxt;
        end
    end

    assign index    = index_nxt;
    assign phase_on = (state_nxt == SCAN_ON);

endmodule

// File: rtl/digseg_scanner.sv
// digseg_scanner
//   Time-multiplexed driver for an N-digit common-anode 7-segment display
//   on the peripheral bus. Holds one {dp, a..g} pattern per digit and a
//   control register, scans the digits with a dead-time blank between
//   them, and drives registered anode/segment outputs.
//
//   Optional feature: define DIGSEG_SCAN_DIM_EN to enable PWM dimming with
//   a 4-bit brightness in ctrl[7:4]. Without it ctrl[7:4] reads 0.
//
// Ports
//   clk     in   clock
//   rst     in   synchronous reset, active-high
//   ce_i    in   bus chip enable
//   we_i    in   bus write enable (1=write, 0=read)
//   addr_i  in   0..NUM_DIGITS-1 digit regs, 4'hF control reg
//   data_i  in   write data {dp, a,b,c,d,e,f,g}
//   data_o  out  read data, valid while ack_o=1
//   ack_o   out  one-cycle bus acknowledge
//   an_o    out  digit select, active-low
//   seg_o   out  segments a..g, active-high
//   dp_o    out  decimal point, active-high
//   Control reg: bit0 = enable, [7:4] = brightness, [3:1] read 0.

module digseg_scanner
    import digseg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [3:0]            addr_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  ack_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  dp_o
);

    localparam int         IDX_W           = $clog2(NUM_DIGITS);
    localparam logic [3:0] LAST_DIGIT_ADDR = 4'(NUM_DIGITS - 1);

    logic [DATA_W-1:0] digit_q [NUM_DIGITS];
    logic              enable_q;

    logic              accept;
    logic              wr_en;
    logic              is_digit;
    logic [IDX_W-1:0]  addr_idx;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] ctrl_rd;

    logic [IDX_W-1:0]  scan_index;
    logic              scan_on;
    logic              slot_end;
    logic [DATA_W-1:0] pattern;
    logic              lit;

    // ---------------------------------------------------------------- bus
    // A transaction is taken only when no ack is outstanding, so a held
    // chip enable produces one transaction every other cycle.
    assign accept   = ce_i & ~ack_o;
    assign wr_en    = accept & we_i;
    assign is_digit = (addr_i <= LAST_DIGIT_ADDR);
    assign addr_idx = addr_i[IDX_W-1:0];

    always_comb begin
        rd_data = '0;
        if (is_digit) begin
            rd_data = digit_q[addr_idx];
        end else if (addr_i == CTRL_ADDR) begin
            rd_data = ctrl_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o  <= accept;
            data_o <= (accept & ~we_i) ? rd_data : '0;
        end
    end

    // ------------------------------------------------------ register file
    // NOTE: the digit array is reset explicitly: it is a handful of flops,
    // not a RAM, and the display must come up showing zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_RESET;
            end
            enable_q <= CTRL_ENABLE_RESET;
        end else if (wr_en) begin
            if (is_digit) begin
                digit_q[addr_idx] <= data_i;
            end else if (addr_i == CTRL_ADDR) begin
                enable_q <= data_i[0];
            end
        end
    end

    // ---------------------------------------------------------- scan timer
    digseg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable_q),
        .index    (scan_index),
        .phase_on (scan_on),
        .slot_end (slot_end)
    );

    // The output stage works from the timer's lookahead index/phase and
    // has no use for the slot boundary pulse.
    logic unused_slot_end;
    assign unused_slot_end = slot_end;

    // ------------------------------------------------------- dimming / ctrl
`ifdef DIGSEG_SCAN_DIM_EN
    logic [3:0] bright_q;
    logic [3:0] pwm_q;
    logic [3:0] pwm_nxt;
    logic       on_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= CTRL_BRIGHT_RESET;
        end else if (wr_en && addr_i == CTRL_ADDR) begin
            bright_q <= data_i[7:4];
        end
    end

    // PWM phase restarts at 0 on the first ON cycle of every slot, then
    // free-runs (wrapping every 16 cycles) until the slot goes blank.
    assign pwm_nxt = on_q ? pwm_q + 4'd1 : 4'd0;
    // Lit while pwm < brightness+1, i.e. (brightness+1)/16 duty.
    assign lit     = (pwm_nxt <= bright_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            on_q  <= 1'b0;
            pwm_q <= '0;
        end else begin
            on_q  <= scan_on;
            pwm_q <= scan_on ? pwm_nxt : 4'd0;
        end
    end

    assign ctrl_rd = {bright_q, 3'b000, enable_q};
`else
    assign lit     = 1'b1;
    assign ctrl_rd = {7'b0000000, enable_q};
`endif

    // ------------------------------------------------------- output stage
    assign pattern = digit_q[scan_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            an_o  <= '1;
            seg_o <= '0;
            dp_o  <= 1'b0;
        end else if (scan_on) begin
            an_o          <= ~(NUM_DIGITS'(1) << scan_index);
            {dp_o, seg_o} <= lit ? pattern : '0;
        end else begin
            an_o  <= '1;
            seg_o <= '0;
            dp_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digseg_scanner.sv
// tb_digseg_scanner
//   Self-checking bench for digseg_scanner with NUM_DIGITS=4, SCAN_DIV=20,
//   BLANK_CYCLES=4. A reference model tracks elapsed scan time and derives
//   the displayed digit arithmetically; bus transactions push expected
//   responses into a scoreboard that a monitor pops on every ack_o.

module tb_digseg_scanner;

    localparam int N  = 4;
    localparam int SD = 20;
    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce, we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] data_o;
    logic       ack_o;
    logic [N-1:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    digseg_scanner #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce),
        .we_i   (we),
        .addr_i (addr),
        .data_i (din),
        .data_o (data_o),
        .ack_o  (ack_o),
        .an_o   (an_o),
        .seg_o  (seg_o),
        .dp_o   (dp_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------ reference model
    typedef struct {
        logic       is_read;
        logic [7:0] data;
    } txn_t;

    txn_t       sb[$];
    logic [7:0] m_digit [N];
    logic       m_en;
    logic       m_ack;
    int         run;        // cycles elapsed since scanning (re)started
    int         start_idx;  // digit shown in the first slot after (re)start
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
`ifdef DIGSEG_SCAN_DIM_EN
    logic [3:0] m_bright;
`endif

    function automatic logic [7:0] model_read(input logic [3:0] a);
        if (a < 4'(N)) return m_digit[a[1:0]];
`ifdef DIGSEG_SCAN_DIM_EN
        if (a == 4'hF) return {m_bright, 3'b000, m_en};
`else
        if (a == 4'hF) return {7'b0, m_en};
`endif
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        int   pos, idx;
        logic lit;
        logic [3:0] one;
        one = 4'b0001;
        if (rst) begin
            for (int i = 0; i < N; i++) m_digit[i] = 8'h7E;
            m_en = 1'b1;
`ifdef DIGSEG_SCAN_DIM_EN
            m_bright = 4'hF;
`endif
            m_ack = 1'b0;
            run = 0;
            start_idx = 0;
            exp_an = 4'hF; exp_seg = 7'h00; exp_dp = 1'b0;
            sb.delete();
        end else begin
            // Display for the coming cycle, from the register values before this edge.
            if (!m_en) begin
                start_idx = (start_idx + run / SD) % N;
                run = 0;
                exp_an = 4'hF; exp_seg = 7'h00; exp_dp = 1'b0;
            end else begin
                run++;
                pos = run % SD;
                idx = (start_idx + run / SD) % N;
                if (pos >= BC) begin
`ifdef DIGSEG_SCAN_DIM_EN
                    lit = ((pos - BC) % 16) < (int'(m_bright) + 1);
`else
                    lit = 1'b1;
`endif
                    exp_an = ~(one << idx);
                    {exp_dp, exp_seg} = lit ? m_digit[idx] : 8'h00;
                end else begin
                    exp_an = 4'hF; exp_seg = 7'h00; exp_dp = 1'b0;
                end
            end
            // Bus transaction accepted at this edge.
            if (ce && !m_ack) begin
                if (we) begin
                    if (addr < 4'(N)) m_digit[addr[1:0]] = din;
                    else if (addr == 4'hF) begin
                        m_en = din[0];
`ifdef DIGSEG_SCAN_DIM_EN
                        m_bright = din[7:4];
`endif
                    end
                    sb.push_back('{is_read: 1'b0, data: 8'h00});
                end else begin
                    sb.push_back('{is_read: 1'b1, data: model_read(addr)});
                end
            end
            m_ack = ce && !m_ack;
        end
    end

    // ------------------------------------------------------------- monitor
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        txn_t t;
        if (mon_en) begin
            check("display", 32'({an_o, dp_o, seg_o}), 32'({exp_an, exp_dp, exp_seg}));
            check("ack_timing", 32'(ack_o), 32'(m_ack));
            if (ack_o) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    t = sb.pop_front();
                    if (t.is_read) check("read_data", 32'(data_o), 32'(t.data));
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // Called at a negedge; returns at the negedge where ack_o is seen.
    task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d,
                       output logic [7:0] q);
        int n = 0;
        while (ack_o && n < 8) begin @(negedge clk); n++; end
        ce = 1'b1; we = w; addr = a; din = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        check("bus_ack", 32'(ack_o), 32'd1);
        q = data_o;
    endtask

    task automatic wait_an(input logic [3:0] v, input string name);
        int n = 0;
        while (an_o !== v && n < 200) begin @(negedge clk); n++; end
        check(name, 32'(an_o), 32'(v));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        int acks;
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 4'h0; din = 8'h00;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst = 1'b0;

        // Reset: 4 blank cycles, then digit 0 showing "0" for 16 cycles.
        check("reset_blank", 32'({an_o, seg_o}), 32'({4'hF, 7'h00}));
        repeat (3) begin
            @(negedge clk);
            check("reset_blank", 32'({an_o, seg_o}), 32'({4'hF, 7'h00}));
        end
        repeat (16) begin
            @(negedge clk);
            check("digit0_on", 32'({an_o, seg_o}), 32'({4'hE, 7'b1111110}));
        end
        @(negedge clk);
        check("slot1_blank", 32'(an_o), 32'h0000000F);

        // Digit write and reads after reset.
        bus(1'b1, 4'h1, 8'hB0, q);
        bus(1'b0, 4'hF, 8'h00, q);
`ifdef DIGSEG_SCAN_DIM_EN
        check("ctrl_reset_read", 32'(q), 32'h000000F1);
`else
        check("ctrl_reset_read", 32'(q), 32'h00000001);
`endif
        bus(1'b0, 4'h9, 8'h00, q);
        check("unmapped_read", 32'(q), 32'h00000000);
        bus(1'b0, 4'h0, 8'h00, q);
        check("digit0_reset_read", 32'(q), 32'h0000007E);
        wait_an(4'hD, "slot1_an");
        check("slot1_dp", 32'(dp_o), 32'd1);
        check("slot1_seg", 32'(seg_o), 32'h00000030);

        // Disable mid-ON of digit 2, then re-enable.
        wait_an(4'hB, "digit2_on");
        repeat (2) @(negedge clk);
        bus(1'b1, 4'hF, 8'h00, q);
        @(negedge clk);
        check("disable_blank", 32'(an_o), 32'h0000000F);
        repeat (5) @(negedge clk);
        check("disabled_held", 32'(an_o), 32'h0000000F);
        bus(1'b1, 4'hF, 8'h01, q);
        repeat (3) begin
            @(negedge clk);
            check("reenable_blank", 32'(an_o), 32'h0000000F);
        end
        @(negedge clk);
        check("reenable_same_digit", 32'(an_o), 32'h0000000B);

`ifdef DIGSEG_SCAN_DIM_EN
        begin
            int n, lit_cnt;
            logic an_ok;
            bus(1'b1, 4'hF, 8'h31, q);
            n = 0;
            while (an_o !== 4'hF && n < 100) begin @(negedge clk); n++; end
            n = 0;
            while (an_o === 4'hF && n < 100) begin @(negedge clk); n++; end
            lit_cnt = 0; an_ok = 1'b1;
            repeat (16) begin
                if (seg_o != 7'h00) lit_cnt++;
                if (an_o === 4'hF) an_ok = 1'b0;
                @(negedge clk);
            end
            check("dim_lit_count", 32'(lit_cnt), 32'd4);
            check("dim_an_held", 32'(an_ok), 32'd1);
            bus(1'b1, 4'hF, 8'hF1, q);
        end
`endif

        // Chip enable held high: one ack every other cycle.
        while (ack_o) @(negedge clk);
        acks = 0;
        ce = 1'b1; we = 1'b0; addr = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_o) acks++;
            addr = 4'((i + 1) % 16);
        end
        ce = 1'b0;
        check("held_ce_acks", 32'(acks), 32'd4);

        // Randomized bus traffic against the model.
        for (int k = 0; k < 150; k++) begin
            int unsigned r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (r < 4) begin
                bus(1'b1, 4'($urandom_range(0, N - 1)), 8'($urandom), q);
            end else if (r == 4) begin
                d = 8'($urandom);
                if ($urandom_range(0, 7) != 0) d[0] = 1'b1;
                bus(1'b1, 4'hF, d, q);
            end else if (r == 5) begin
                bus(1'b1, 4'($urandom_range(4, 14)), 8'($urandom), q);
            end else begin
                bus(1'b0, 4'($urandom_range(0, 15)), 8'h00, q);
            end
        end

        // Reset during ON of digit 3.
        bus(1'b1, 4'hF, 8'hF1, q);
        wait_an(4'h7, "digit3_on");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_blank", 32'(an_o), 32'h0000000F);
        rst = 1'b0;
        begin
            int n = 0;
            while (an_o === 4'hF && n < 20) begin @(negedge clk); n++; end
            check("rst_index0", 32'(an_o), 32'h0000000E);
        end
        for (int i = 0; i < N; i++) begin
            bus(1'b0, 4'(i), 8'h00, q);
            check("rst_digit_read", 32'(q), 32'h0000007E);
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
